// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// controller states and the alignment rule used by the lane logic.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Size 11 is reserved and always rejected; halves need an even address,
    // words need a word-aligned address.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension,
// store merge into the existing RAM word, and misalignment detection.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        ldunsigned,
    input  logic [31:0] ram_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the stored word (little-endian).
    always_comb begin
        byte_s = ram_word[{lane, 3'b000} +: 8];
        if (lane[1]) begin
            half_s = ram_word[31:16];
        end else begin
            half_s = ram_word[15:0];
        end
    end

    // Extend the selected lane to 32 bits; words pass through untouched.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = ldunsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = ldunsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_WORD: load_data = ram_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Overwrite only the addressed lane(s); every other byte keeps its value.
    always_comb begin
        merged_word = ram_word;
        case (size)
            SZ_BYTE: merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
            SZ_HALF: merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
            SZ_WORD: merged_word = store_data;
            default: merged_word = ram_word;
        endcase
    end

    // Flag accesses that must be rejected.
    always_comb begin
        misalign = is_misaligned(size, lane);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: latches a load/store request, stalls
// the datapath for a fixed number of wait cycles, then returns extended load
// data or commits the store into an internal word RAM.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        ldunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign_err
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic [AW+1:0]   addr_r;
    logic [1:0]      size_r;
    logic            uns_r;
    logic            wr_r;
    logic [31:0]     wdata_r;
    logic [31:0]     readdata_r;
    logic            misalign_r;
    logic [31:0]     ram_r [DEPTH_WORDS];

    logic [AW+1:0]   eff_addr_s;
    logic [1:0]      eff_size_s;
    logic            eff_uns_s;
    logic            eff_wr_s;
    logic [31:0]     eff_wdata_s;
    logic [31:0]     load_s;
    logic [31:0]     merged_s;
    logic            mis_s;
    logic [31:0]     resp_data_s;
    logic            stall_s;
    logic            unused_addr_s;

    // Address bits above the RAM range are ignored so accesses wrap.
    assign unused_addr_s = ^addr[31:AW+2];

    // In IDLE the live request feeds the lane logic (needed for zero-wait
    // accesses); otherwise the latched copy is used and inputs are don't-care.
    always_comb begin
        if (state_r == IDLE) begin
            eff_addr_s  = addr[AW+1:0];
            eff_size_s  = size;
            eff_uns_s   = ldunsigned;
            eff_wr_s    = memwrite;
            eff_wdata_s = writedata;
        end else begin
            eff_addr_s  = addr_r;
            eff_size_s  = size_r;
            eff_uns_s   = uns_r;
            eff_wr_s    = wr_r;
            eff_wdata_s = wdata_r;
        end
    end

    dmem_align u_align (
        .size        (eff_size_s),
        .lane        (eff_addr_s[1:0]),
        .ldunsigned  (eff_uns_s),
        .ram_word    (ram_r[eff_addr_s[AW+1:2]]),
        .store_data  (eff_wdata_s),
        .load_data   (load_s),
        .merged_word (merged_s),
        .misalign    (mis_s)
    );

    // Stores and rejected accesses return zero; loads return extended data.
    always_comb begin
        if (eff_wr_s || mis_s) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = load_s;
        end
    end

    // Stall covers the request cycle and all BUSY cycles, never during reset.
    always_comb begin
        if (!reset) begin
            stall_s = 1'b0;
        end else if (state_r == IDLE) begin
            stall_s = memread | memwrite;
        end else if (state_r == BUSY) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Controller FSM: request latch, wait countdown, registered response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= '0;
            size_r     <= 2'b00;
            uns_r      <= 1'b0;
            wr_r       <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            readdata_r <= 32'h0000_0000;
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (memread || memwrite) begin
                        addr_r  <= addr[AW+1:0];
                        size_r  <= size;
                        uns_r   <= ldunsigned;
                        wr_r    <= memwrite;
                        wdata_r <= writedata;
                        if (WAIT_L == 4'd0) begin
                            state_r    <= DONE;
                            readdata_r <= resp_data_s;
                            misalign_r <= mis_s;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= WAIT_L;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r <= 4'd1) begin
                        state_r    <= DONE;
                        cnt_r      <= 4'd0;
                        readdata_r <= resp_data_s;
                        misalign_r <= mis_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Store commit at the end of DONE; a reset on that edge cancels it and
    // reset never clears the array itself.
    always_ff @(posedge clk) begin
        if (reset && (state_r == DONE) && wr_r && !mis_s) begin
            ram_r[addr_r[AW+1:2]] <= merged_s;
        end
    end

    assign readdata     = readdata_r;
    assign misalign_err = misalign_r;
    assign stall        = stall_s;

endmodule
